// File: rtl/cache_refill_ctrl.sv
// Miss-side refill engine for the 2-way, 8-index instruction cache: fetches a
// 32-byte line as eight beats, writes it into the LRU victim way.
module cache_refill_ctrl #(
    parameter int ADDR_W     = 32,
    parameter int LINE_WORDS = 8,
    parameter int IDX_W      = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    miss,
    input  logic [ADDR_W-1:0]       miss_addr,
    input  logic                    hit,
    input  logic                    hit_way,
    input  logic [IDX_W-1:0]        hit_index,
    output logic                    mem_req,
    output logic [ADDR_W-1:0]       mem_addr,
    input  logic                    mem_ack,
    input  logic                    mem_rvalid,
    input  logic [31:0]             mem_rdata,
    output logic [32*LINE_WORDS-1:0] fill_data,
    output logic [ADDR_W-IDX_W-6:0] fill_tag,
    output logic [IDX_W-1:0]        fill_index,
    output logic                    fill_valid,
    output logic                    we_set0,
    output logic                    we_set1,
    output logic                    busy,
    output logic                    done
);

    localparam int CNT_W = $clog2(LINE_WORDS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LINE_WORDS - 1);
    localparam logic [ADDR_W-1:0] OFFSET_MASK = ADDR_W'(5'h1f);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        FILL,
        WRITE,
        DONE
    } state_t;

    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    logic [(1<<IDX_W)-1:0]   lru;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            lru        <= '0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            fill_data  <= '0;
            fill_tag   <= '0;
            fill_index <= '0;
            fill_valid <= 1'b0;
            we_set0    <= 1'b0;
            we_set1    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            if (hit)
                lru[hit_index] <= ~hit_way;

            case (state)
                IDLE: begin
                    if (miss) begin
                        mem_addr   <= miss_addr & ~OFFSET_MASK;
                        fill_tag   <= miss_addr[ADDR_W-1:IDX_W+5];
                        fill_index <= miss_addr[IDX_W+4:5];
                        fill_data  <= '0;
                        mem_req    <= 1'b1;
                        busy       <= 1'b1;
                        state      <= REQ;
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        cnt     <= '0;
                        state   <= FILL;
                    end
                end
                FILL: begin
                    // Strobes are decided on the last beat so they are live in WRITE.
                    if (mem_rvalid) begin
                        fill_data[{cnt, 5'b0} +: 32] <= mem_rdata;
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST_BEAT) begin
                            we_set0    <= ~lru[fill_index];
                            we_set1    <= lru[fill_index];
                            fill_valid <= 1'b1;
                            state      <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    // Placed after the hit update so the refill wins on the same index.
                    lru[fill_index] <= we_set0;
                    we_set0    <= 1'b0;
                    we_set1    <= 1'b0;
                    fill_valid <= 1'b0;
                    done       <= 1'b1;
                    state      <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Self-checking bench for cache_refill_ctrl: directed vector table, hand-written
// corner sequences, and randomized refills against an LRU reference model.
module tb_cache_refill_ctrl;

    logic         clk = 1'b0;
    logic         reset;
    logic         miss;
    logic [31:0]  miss_addr;
    logic         hit;
    logic         hit_way;
    logic [2:0]   hit_index;
    logic         mem_req;
    logic [31:0]  mem_addr;
    logic         mem_ack;
    logic         mem_rvalid;
    logic [31:0]  mem_rdata;
    logic [255:0] fill_data;
    logic [23:0]  fill_tag;
    logic [2:0]   fill_index;
    logic         fill_valid;
    logic         we_set0;
    logic         we_set1;
    logic         busy;
    logic         done;

    cache_refill_ctrl dut (
        .clk(clk), .reset(reset), .miss(miss), .miss_addr(miss_addr),
        .hit(hit), .hit_way(hit_way), .hit_index(hit_index),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .fill_data(fill_data), .fill_tag(fill_tag), .fill_index(fill_index),
        .fill_valid(fill_valid), .we_set0(we_set0), .we_set1(we_set1),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;
    bit lru_model [8];
    logic [31:0] beats [8];

    typedef struct {
        logic [31:0] addr;
        int          ack_delay;
        int          gap;
        bit          noise;
        bit          fill_miss;
        int          write_hit;
        bit          pre_hit;
        bit          pre_hit_way;
        logic [2:0]  pre_hit_idx;
        logic [31:0] exp_mem_addr;
        logic [23:0] exp_tag;
        logic [2:0]  exp_idx;
        bit          exp_way;
    } vec_t;

    vec_t vecs [5];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic doReset;
        reset = 1'b1;
        miss = 1'b0; miss_addr = '0; hit = 1'b0; hit_way = 1'b0; hit_index = '0;
        mem_ack = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        tick;
        tick;
        reset = 1'b0;
        for (int i = 0; i < 8; i++) lru_model[i] = 1'b0;
    endtask

    task automatic applyHit(input bit way, input logic [2:0] idx);
        hit = 1'b1; hit_way = way; hit_index = idx;
        tick;
        hit = 1'b0;
        lru_model[idx] = !way;
    endtask

    // One complete refill driven from IDLE; beats[] holds the line contents.
    task automatic applyStimulus(input vec_t v);
        logic [255:0] exp_line;
        bit victim;
        for (int k = 0; k < 8; k++) exp_line[32*k +: 32] = beats[k];
        victim = v.exp_way;

        if (v.noise) begin
            mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF; mem_ack = 1'b1;
            tick;
            mem_rvalid = 1'b0; mem_ack = 1'b0;
            checkOutput("idle_noise_busy", busy, 1'b0);
        end

        miss = 1'b1; miss_addr = v.addr;
        tick;
        miss = 1'b0;
        checkOutput("mem_req_rise", mem_req, 1'b1);
        checkOutput("mem_addr", mem_addr, v.exp_mem_addr);
        checkOutput("busy_req", busy, 1'b1);

        for (int d = 0; d < v.ack_delay; d++) begin
            if (v.noise && d == 0) begin
                mem_rvalid = 1'b1; mem_rdata = 32'hBADC0DE0;
            end
            tick;
            mem_rvalid = 1'b0;
            checkOutput("mem_req_hold", mem_req, 1'b1);
            checkOutput("mem_addr_hold", mem_addr, v.exp_mem_addr);
        end

        mem_ack = 1'b1;
        tick;
        mem_ack = 1'b0;
        checkOutput("mem_req_drop", mem_req, 1'b0);

        for (int k = 0; k < 8; k++) begin
            mem_rvalid = 1'b1; mem_rdata = beats[k];
            if (v.fill_miss && k == 3) begin
                miss = 1'b1; miss_addr = v.addr ^ 32'h0000_0100;
            end
            tick;
            mem_rvalid = 1'b0; miss = 1'b0;
            if (k < 7) begin
                for (int g = 0; g < v.gap; g++) begin
                    tick;
                    checkOutput("no_early_we", we_set0 | we_set1, 1'b0);
                end
            end
        end

        checkOutput("we_set0", we_set0, !victim);
        checkOutput("we_set1", we_set1, victim);
        checkOutput("fill_valid", fill_valid, 1'b1);
        checkOutput("fill_data", fill_data, exp_line);
        checkOutput("fill_tag", fill_tag, v.exp_tag);
        checkOutput("fill_index", fill_index, v.exp_idx);
        checkOutput("mem_addr_fill", mem_addr, v.exp_mem_addr);

        if (v.write_hit >= 0) begin
            hit = 1'b1; hit_way = v.write_hit[0]; hit_index = v.exp_idx;
        end
        tick;
        hit = 1'b0;
        lru_model[v.exp_idx] = !victim;
        checkOutput("done_pulse", done, 1'b1);
        checkOutput("we_drop", we_set0 | we_set1, 1'b0);
        checkOutput("fill_valid_drop", fill_valid, 1'b0);
        checkOutput("fill_data_hold", fill_data, exp_line);

        tick;
        checkOutput("done_clear", done, 1'b0);
        checkOutput("busy_clear", busy, 1'b0);
    endtask

    task automatic tableBeats;
        for (int k = 0; k < 8; k++) beats[k] = 32'h1111_1111 * (k + 1);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t v;

        vecs[0] = '{32'h0000_0A47, 2, 0, 0, 0, -1, 0, 0, 3'd0, 32'h0000_0A40, 24'h00000A, 3'd2, 0};
        vecs[1] = '{32'h0000_0B40, 0, 0, 0, 0, -1, 0, 0, 3'd0, 32'h0000_0B40, 24'h00000B, 3'd2, 1};
        vecs[2] = '{32'h0000_0C40, 1, 0, 0, 0, -1, 0, 0, 3'd0, 32'h0000_0C40, 24'h00000C, 3'd2, 0};
        vecs[3] = '{32'h0000_00A0, 1, 0, 0, 0, -1, 1, 0, 3'd5, 32'h0000_00A0, 24'h000000, 3'd5, 1};
        vecs[4] = '{32'h0000_0A40, 2, 2, 1, 0, -1, 0, 0, 3'd0, 32'h0000_0A40, 24'h00000A, 3'd2, 1};

        doReset;
        checkOutput("rst_mem_req", mem_req, 1'b0);
        checkOutput("rst_mem_addr", mem_addr, 32'h0);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_done", done, 1'b0);
        checkOutput("rst_we", {we_set1, we_set0}, 2'b00);
        checkOutput("rst_fill_valid", fill_valid, 1'b0);
        checkOutput("rst_fill_data", fill_data, 256'h0);
        checkOutput("rst_fill_tag", fill_tag, 24'h0);
        checkOutput("rst_fill_index", fill_index, 3'h0);

        tableBeats;
        for (int i = 0; i < 5; i++) begin
            if (vecs[i].pre_hit) applyHit(vecs[i].pre_hit_way, vecs[i].pre_hit_idx);
            applyStimulus(vecs[i]);
        end

        // Miss ignored during FILL; hit in the WRITE cycle loses to the refill.
        doReset;
        v = '{32'h0000_0340, 0, 1, 0, 1, 0, 0, 0, 3'd0, 32'h0000_0340, 24'h000003, 3'd2, 0};
        applyStimulus(v);
        v = '{32'h0000_0440, 1, 0, 0, 0, 0, 0, 0, 3'd0, 32'h0000_0440, 24'h000004, 3'd2, 1};
        applyStimulus(v);
        v = '{32'h0000_0540, 0, 0, 0, 0, -1, 0, 0, 3'd0, 32'h0000_0540, 24'h000005, 3'd2, 0};
        applyStimulus(v);

        // Reset while in REQ drops mem_req.
        miss = 1'b1; miss_addr = 32'h0000_0060;
        tick;
        miss = 1'b0;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        for (int i = 0; i < 8; i++) lru_model[i] = 1'b0;
        checkOutput("rst_req_mem_req", mem_req, 1'b0);
        checkOutput("rst_req_busy", busy, 1'b0);

        // Reset after the 4th beat aborts with no strobe; a new miss starts over.
        miss = 1'b1; miss_addr = 32'h0000_01E0;
        tick;
        miss = 1'b0;
        mem_ack = 1'b1;
        tick;
        mem_ack = 1'b0;
        for (int k = 0; k < 4; k++) begin
            mem_rvalid = 1'b1; mem_rdata = 32'hA5A5_0000 + k;
            tick;
            mem_rvalid = 1'b0;
        end
        reset = 1'b1;
        tick;
        reset = 1'b0;
        for (int i = 0; i < 8; i++) lru_model[i] = 1'b0;
        checkOutput("abort_busy", busy, 1'b0);
        checkOutput("abort_fill_data", fill_data, 256'h0);
        checkOutput("abort_we", {we_set1, we_set0}, 2'b00);
        for (int i = 0; i < 3; i++) begin
            tick;
            checkOutput("abort_no_we", {we_set1, we_set0}, 2'b00);
            checkOutput("abort_no_done", done, 1'b0);
        end
        for (int k = 0; k < 8; k++) beats[k] = $urandom;
        v = '{32'h0000_01E0, 0, 0, 0, 0, -1, 0, 0, 3'd0, 32'h0000_01E0, 24'h000001, 3'd7, 0};
        applyStimulus(v);

        // Randomized refills and hits against the LRU reference model.
        for (int n = 0; n < 30; n++) begin
            logic [31:0] a;
            int hits;
            hits = $urandom_range(0, 3);
            for (int h = 0; h < hits; h++) begin
                bit w;
                logic [2:0] idx;
                w = 1'($urandom_range(0, 1));
                idx = 3'($urandom_range(0, 7));
                applyHit(w, idx);
            end
            a = $urandom;
            for (int k = 0; k < 8; k++) beats[k] = $urandom;
            v.addr         = a;
            v.ack_delay    = $urandom_range(0, 3);
            v.gap          = $urandom_range(0, 2);
            v.noise        = 1'($urandom_range(0, 1));
            v.fill_miss    = 1'($urandom_range(0, 1));
            v.write_hit    = int'($urandom_range(0, 2)) - 1;
            v.pre_hit      = 1'b0;
            v.pre_hit_way  = 1'b0;
            v.pre_hit_idx  = '0;
            v.exp_mem_addr = (a / 32) * 32;
            v.exp_tag      = 24'(a >> 8);
            v.exp_idx      = 3'((a >> 5) % 8);
            v.exp_way      = lru_model[(a >> 5) % 8];
            applyStimulus(v);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/cache_refill_ctrl.md
Name: cache_refill_ctrl

Overview:
Miss-side refill engine for the 2-way, 8-index, 32-byte-line instruction cache. On a lookup miss it fetches the full line from memory as eight 32-bit beats and packs them into a 256-bit line buffer. It then writes the line, tag and valid bit into the victim way's cache_set. It also keeps one LRU bit per index; hits and refills update it.

Parameters:
ADDR_W, 32, address width.
LINE_WORDS, 8, beats per line (fixed; 32-bit beats, 256-bit line).
IDX_W, 3, index width; index = addr[7:5].

Ports:
clk  in  1  clock.
reset  in  1  synchronous, active-high reset.
miss  in  1  lookup at miss_addr missed; sampled in IDLE only.
miss_addr  in  32  address that missed.
hit  in  1  lookup hit this cycle.
hit_way  in  1  way that hit (0 = set0, 1 = set1).
hit_index  in  3  index of the hit.
mem_req  out  1  line-fill request to memory.
mem_addr  out  32  line base address (miss_addr with [4:0] cleared).
mem_ack  in  1  memory accepted the request.
mem_rvalid  in  1  memory read beat valid.
mem_rdata  in  32  memory read beat.
fill_data  out  256  assembled line to cache_set inputData.
fill_tag  out  24  miss_addr[31:8] to cache_set in_tag.
fill_index  out  3  miss_addr[7:5]; drives the cache decoder during a write.
fill_valid  out  1  valid bit written with the line.
we_set0  out  1  write strobe, way 0.
we_set1  out  1  write strobe, way 1.
busy  out  1  refill in progress.
done  out  1  one-cycle pulse, refill complete.

Behaviour:
- Clock and reset: one clock (clk), synchronous active-high reset (reset). All outputs, fill_data, the beat counter and all 8 LRU bits reset to 0, and the FSM goes to IDLE.
- Registers: all outputs are registered.
- FSM states: IDLE, REQ, FILL, WRITE, DONE.
- busy: 1 in REQ, FILL, WRITE and DONE.
- IDLE:
  - miss=1 captures the line base, tag and index, and moves to REQ.
  - mem_req=1 on the next cycle, so latency from miss to mem_req is 1 cycle.
- REQ:
  - mem_req=1 and mem_addr stays stable until mem_ack=1.
  - On ack: go to FILL, clear the beat counter, and drop mem_req the following cycle.
- FILL:
  - Each mem_rvalid=1 writes mem_rdata to fill_data[32*cnt+31 : 32*cnt], then cnt increments.
  - Beat 0 is the lowest address and lands in bits [31:0].
  - Gaps in rvalid are allowed; cnt advances only on rvalid.
  - After beat 7, go to WRITE.
- WRITE (exactly 1 cycle, 1 cycle after the last beat):
  - Victim = lru[fill_index]; we_set0 = (victim==0), we_set1 = (victim==1). Exactly one strobe is high.
  - fill_valid=1.
  - lru[fill_index] <= ~victim.
  - fill_data, fill_tag and fill_index stay stable through this cycle.
- DONE: done=1 for 1 cycle, then return to IDLE.
- Output hold: fill_data, fill_tag and fill_index hold their values until the next miss is captured.
- LRU on hit: when hit=1 in any state, lru[hit_index] <= ~hit_way.
  - If a WRITE update and a hit target the same index in the same cycle, the WRITE update wins.
  - Hits to different indices update independently.
- Ignored inputs:
  - miss while busy.
  - mem_rvalid in IDLE, REQ, WRITE or DONE.
  - mem_ack outside REQ.
- Reset mid-operation:
  - Aborts the refill; no write strobe is issued; fill_data clears to 0; mem_req drops the next cycle.
  - A later miss restarts from beat 0.
- Invariant: we_set0 and we_set1 are never high together.

Test Plan:
1. Reset, then miss with miss_addr=0x0000_0A47; ack after 2 cycles; beats k=0..7 with data 0x1111_1111*(k+1).
   -> mem_addr=0x0000_0A40, fill_index=2, fill_tag=0x00000A.
   -> fill_data[31:0]=0x1111_1111 and fill_data[255:224]=0x8888_8888.
   -> we_set0=1 for one cycle, exactly 1 cycle after the last beat; done pulses on the next cycle.
2. Three back-to-back misses to index 2 (addresses 0x0A40, 0x0B40, 0x0C40) -> victims are way0, then way1, then way0.
3. After reset, hit=1 with hit_way=0 and hit_index=5, then a miss at 0x0000_00A0 (index 5) -> we_set1=1.
4. Beats delivered with rvalid high every third cycle, plus rvalid pulses while in IDLE and REQ -> only the 8 FILL beats are packed, in order; line contents match case 1.
5. Reset asserted after the 4th beat -> no we strobe; busy=0 and fill_data=0 the next cycle; lru[index] unchanged. A new miss refills correctly from beat 0.
6. miss asserted during FILL is ignored (mem_addr unchanged). hit with hit_way=0 at fill_index in the WRITE cycle of a way-0 fill -> lru[index]=1 (the WRITE update wins).
